// File: rtl/sc_reg_shifter.sv
// sc_reg_shifter
//   Loadable multi-cycle shift register on the uDataPath bus. It captures the operand
//   bus on a Start request and shifts it N positions, one bit per falling clock edge,
//   under a start/busy/done handshake. The result stays on the output bus until the
//   next Start or reset.
//
//   Optional feature macro: SC_REGSHIFTER_ROTATE_EN
//     defined     : Mode_In = 1 selects rotate (the bit shifted out re-enters the vacated end)
//     not defined : Mode_In is ignored and every operation is a logical shift
//
// Ports
//   SC_RegSHIFTER_CLOCK_50     in   system clock, state updates on the falling edge
//   SC_RegSHIFTER_Reset_InLow  in   asynchronous reset, active-low
//   SC_RegSHIFTER_DataBUS_In   in   operand bus, loaded on Start
//   SC_RegSHIFTER_Start_In     in   start request, honoured only in IDLE
//   SC_RegSHIFTER_Amount_In    in   shift count N, latched with Start
//   SC_RegSHIFTER_Dir_In       in   0 = left, 1 = right, latched with Start
//   SC_RegSHIFTER_Mode_In      in   0 = logical, 1 = rotate (rotate build only)
//   SC_RegSHIFTER_DataBUS_Out  out  shift register contents
//   SC_RegSHIFTER_Busy_Out     out  high in SHIFT and DONE
//   SC_RegSHIFTER_Done_Out     out  one-cycle result-valid pulse
module sc_reg_shifter #(
   parameter int unsigned                 DATAWIDTH_BUS      = 32,
   parameter int unsigned                 SHIFTCOUNT_WIDTH   = 5,
   parameter logic [DATAWIDTH_BUS-1:0]    DATA_REGSHIFT_INIT = '0
) (
   input  logic                          SC_RegSHIFTER_CLOCK_50,
   input  logic                          SC_RegSHIFTER_Reset_InLow,
   input  logic [DATAWIDTH_BUS-1:0]      SC_RegSHIFTER_DataBUS_In,
   input  logic                          SC_RegSHIFTER_Start_In,
   input  logic [SHIFTCOUNT_WIDTH-1:0]   SC_RegSHIFTER_Amount_In,
   input  logic                          SC_RegSHIFTER_Dir_In,
   input  logic                          SC_RegSHIFTER_Mode_In,
   output logic [DATAWIDTH_BUS-1:0]      SC_RegSHIFTER_DataBUS_Out,
   output logic                          SC_RegSHIFTER_Busy_Out,
   output logic                          SC_RegSHIFTER_Done_Out
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t                        r_state;
   logic [DATAWIDTH_BUS-1:0]      r_data;
   logic [SHIFTCOUNT_WIDTH-1:0]   r_count;
   logic                          r_dir;
   logic                          w_rotate;
   logic                          w_fill_lsb;
   logic                          w_fill_msb;
   logic [DATAWIDTH_BUS-1:0]      w_shifted;

`ifdef SC_REGSHIFTER_ROTATE_EN
   logic                          r_mode;

   assign w_rotate = r_mode;
`else
   logic                          w_unused_mode;

   assign w_unused_mode = SC_RegSHIFTER_Mode_In;
   assign w_rotate      = 1'b0;
`endif

   // Vacated end receives the bit shifted out when rotating, zero otherwise.
   always_comb begin
      w_fill_lsb = w_rotate & r_data[DATAWIDTH_BUS-1];
      w_fill_msb = w_rotate & r_data[0];
      w_shifted  = r_data;
      if (r_dir)
         w_shifted = {w_fill_msb, r_data[DATAWIDTH_BUS-1:1]};
      else
         w_shifted = {r_data[DATAWIDTH_BUS-2:0], w_fill_lsb};
   end

   always_ff @(negedge SC_RegSHIFTER_CLOCK_50 or negedge SC_RegSHIFTER_Reset_InLow) begin
      if (!SC_RegSHIFTER_Reset_InLow) begin
         r_state <= ST_IDLE;
         r_data  <= DATA_REGSHIFT_INIT;
         r_count <= '0;
         r_dir   <= 1'b0;
`ifdef SC_REGSHIFTER_ROTATE_EN
         r_mode  <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (SC_RegSHIFTER_Start_In) begin
                  r_data  <= SC_RegSHIFTER_DataBUS_In;
                  r_count <= SC_RegSHIFTER_Amount_In;
                  r_dir   <= SC_RegSHIFTER_Dir_In;
`ifdef SC_REGSHIFTER_ROTATE_EN
                  r_mode  <= SC_RegSHIFTER_Mode_In;
`endif
                  r_state <= (SC_RegSHIFTER_Amount_In == '0) ? ST_DONE : ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               r_data  <= w_shifted;
               r_count <= r_count - SHIFTCOUNT_WIDTH'(1);
               if (r_count == SHIFTCOUNT_WIDTH'(1))
                  r_state <= ST_DONE;
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign SC_RegSHIFTER_DataBUS_Out = r_data;
   assign SC_RegSHIFTER_Busy_Out    = (r_state != ST_IDLE);
   assign SC_RegSHIFTER_Done_Out    = (r_state == ST_DONE);

endmodule

// File: tb/tb_sc_reg_shifter.sv
// tb_sc_reg_shifter
//   Directed bench for sc_reg_shifter (32-bit bus). The DUT acts on falling edges;
//   inputs are driven and outputs sampled on rising edges.
module tb_sc_reg_shifter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] data_in;
   logic        start;
   logic [4:0]  amt;
   logic        dir;
   logic        mode;
   logic [31:0] data_out;
   logic        busy;
   logic        done;

   int n_tests = 0;
   int n_fail  = 0;

   sc_reg_shifter #(
      .DATAWIDTH_BUS      (32),
      .SHIFTCOUNT_WIDTH   (5),
      .DATA_REGSHIFT_INIT (32'h0000_0000)
   ) dut (
      .SC_RegSHIFTER_CLOCK_50    (clk),
      .SC_RegSHIFTER_Reset_InLow (rst_n),
      .SC_RegSHIFTER_DataBUS_In  (data_in),
      .SC_RegSHIFTER_Start_In    (start),
      .SC_RegSHIFTER_Amount_In   (amt),
      .SC_RegSHIFTER_Dir_In      (dir),
      .SC_RegSHIFTER_Mode_In     (mode),
      .SC_RegSHIFTER_DataBUS_Out (data_out),
      .SC_RegSHIFTER_Busy_Out    (busy),
      .SC_RegSHIFTER_Done_Out    (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Start one operation, then watch it to completion. While busy, the operand,
   // amount and direction inputs are scrambled and optionally Start is re-pulsed;
   // none of that may disturb the result.
   task automatic run_op(input string tag, input logic [31:0] d, input int n,
                         input logic dr, input logic md, input logic stray,
                         input logic [31:0] exp);
      int busy_cnt;
      int done_cnt;
      int done_idx;
      @(posedge clk);
      data_in = d;
      amt     = 5'(n);
      dir     = dr;
      mode    = md;
      start   = 1'b1;
      @(posedge clk);
      start    = 1'b0;
      busy_cnt = 0;
      done_cnt = 0;
      done_idx = 0;
      for (int i = 1; i <= 64 && busy; i++) begin
         busy_cnt++;
         if (done) begin
            done_cnt++;
            if (done_idx == 0) done_idx = i;
         end
         data_in = $urandom;
         amt     = 5'($urandom);
         dir     = ~dr;
         mode    = ~md;
         start   = stray && !done;
         @(posedge clk);
      end
      start = 1'b0;
      check({tag, "/busy_cycles"}, 32'(busy_cnt), 32'(n + 1));
      check({tag, "/done_pulses"}, 32'(done_cnt), 32'd1);
      check({tag, "/done_latency"}, 32'(done_idx), 32'(n + 1));
      check({tag, "/result"}, data_out, exp);
      check({tag, "/busy_idle"}, 32'(busy), 32'd0);
      repeat (3) @(posedge clk);
      check({tag, "/held"}, data_out, exp);
      check({tag, "/still_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n   = 1'b0;
      data_in = '0;
      start   = 1'b0;
      amt     = '0;
      dir     = 1'b0;
      mode    = 1'b0;
      #1;
      check("reset/out",  data_out,    32'h0000_0000);
      check("reset/busy", 32'(busy),   32'd0);
      check("reset/done", 32'(done),   32'd0);
      repeat (2) @(posedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      check("post_reset/busy", 32'(busy), 32'd0);

      run_op("t1_left4",     32'h0000_00F0, 4, 1'b0, 1'b0, 1'b0, 32'h0000_0F00);
      run_op("t2_zero",      32'h8000_0001, 0, 1'b0, 1'b0, 1'b0, 32'h8000_0001);
`ifdef SC_REGSHIFTER_ROTATE_EN
      run_op("t3_rotr1",     32'h0000_0003, 1, 1'b1, 1'b1, 1'b0, 32'h8000_0001);
      run_op("rotl4",        32'h8000_0001, 4, 1'b0, 1'b1, 1'b1, 32'h0000_0018);
`else
      run_op("t3_rotr1",     32'h0000_0003, 1, 1'b1, 1'b1, 1'b0, 32'h0000_0001);
      run_op("rotl4",        32'h8000_0001, 4, 1'b0, 1'b1, 1'b1, 32'h0000_0010);
`endif
      run_op("t4_left31",    32'hFFFF_FFFF, 31, 1'b0, 1'b0, 1'b1, 32'h8000_0000);
      run_op("right8",       32'hF000_0000, 8, 1'b1, 1'b0, 1'b1, 32'h00F0_0000);
      run_op("right31",      32'h8000_0000, 31, 1'b1, 1'b0, 1'b0, 32'h0000_0001);

      // Reset in the middle of a 10-bit shift: edge 1 loads, edges 2..4 shift by 3.
      @(posedge clk);
      data_in = 32'h0000_0001;
      amt     = 5'd10;
      dir     = 1'b0;
      mode    = 1'b0;
      start   = 1'b1;
      @(posedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      check("t5/busy_before", 32'(busy), 32'd1);
      check("t5/out_before",  data_out,  32'h0000_0008);
      #2 rst_n = 1'b0;
      #1;
      check("t5/out_reset",  data_out,  32'h0000_0000);
      check("t5/busy_reset", 32'(busy), 32'd0);
      check("t5/done_reset", 32'(done), 32'd0);
      @(posedge clk);
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      check("t5/idle_busy", 32'(busy), 32'd0);
      check("t5/idle_done", 32'(done), 32'd0);
      check("t5/idle_out",  data_out,  32'h0000_0000);

      run_op("after_reset",  32'h1234_5678, 4, 1'b1, 1'b0, 1'b0, 32'h0123_4567);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
